// File: rtl/roll_fmt_pkg.sv
// Shared definitions for the dice-roll message formatter:
// ASCII byte constants, message lengths, FSM state type and
// the byte selector for the fixed "Rolled: D\n" body.
package roll_fmt_pkg;

    localparam logic [7:0] ASC_R     = 8'h52;
    localparam logic [7:0] ASC_O     = 8'h6F;
    localparam logic [7:0] ASC_L     = 8'h6C;
    localparam logic [7:0] ASC_E     = 8'h65;
    localparam logic [7:0] ASC_D     = 8'h64;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_HASH  = 8'h23;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    localparam int MSG_LEN_BASE = 10;
    localparam int MSG_LEN_SEQ  = 14;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Result digit: legal dice values map to '1'..'6', anything else to bad.
    function automatic logic [7:0] digit_char(input logic [2:0] v,
                                              input logic [7:0] bad);
        if (v >= 3'd1 && v <= 3'd6) begin
            return ASC_ZERO + {5'd0, v};
        end
        return bad;
    endfunction

    // Byte i (0..9) of the "Rolled: D\n" body.
    function automatic logic [7:0] base_byte(input logic [3:0] i,
                                             input logic [2:0] v,
                                             input logic [7:0] bad);
        case (i)
            4'd0:    return ASC_R;
            4'd1:    return ASC_O;
            4'd2:    return ASC_L;
            4'd3:    return ASC_L;
            4'd4:    return ASC_E;
            4'd5:    return ASC_D;
            4'd6:    return ASC_COLON;
            4'd7:    return ASC_SPACE;
            4'd8:    return digit_char(v, bad);
            default: return ASC_LF;
        endcase
    endfunction

endpackage

// File: rtl/roll_fifo.sv
// Synchronous result FIFO. Caller only asserts push_i when there is room
// or when pop_i is asserted in the same cycle (push+pop while full is legal:
// the head slot is read out on the same edge it is overwritten).
module roll_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/roll_msg_formatter.sv
// Turns dice results into ASCII "Rolled: D\n" messages on a valid/ready
// byte stream. Results queue in a small FIFO; one message is sent at a time.
// Build option: define ROLL_SEQ_EN to prefix each message with "#SS ",
// a two-digit BCD message sequence number.
module roll_msg_formatter
    import roll_fmt_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2:0]                    res_val,
    input  logic                          res_valid,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
`ifdef ROLL_SEQ_EN
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN_SEQ - 1);
    localparam logic [3:0] BASE_OFS = 4'(MSG_LEN_SEQ - MSG_LEN_BASE);
`else
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN_BASE - 1);
    localparam logic [3:0] BASE_OFS = 4'd0;
`endif

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] val_q, val_d;
    logic       overflow_q, overflow_d;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2:0] fifo_head;
    logic       handshake, last_byte;

    // A write into a full FIFO is still accepted if the head leaves this cycle.
    assign fifo_push = res_valid && (!fifo_full || fifo_pop);

    roll_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (3)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (res_val),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign out_valid = (state_q == SEND);
    assign handshake = out_valid && out_ready;
    assign last_byte = (idx_q == LAST_IDX);
    assign busy      = (state_q == SEND) || (fifo_level != '0);
    assign overflow  = overflow_q;

    // Control state: FSM, byte index and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Result latched at pop time so later FIFO writes cannot disturb the message.
    always_ff @(posedge clk) begin
        val_q <= val_d;
    end

    // Next-state: pop when idle and data waits; step through bytes on handshakes.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        val_d    = val_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    val_d    = fifo_head;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (last_byte) state_d = IDLE;
                    else           idx_d   = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        overflow_d = overflow_q || (res_valid && fifo_full && !fifo_pop);
    end

`ifdef ROLL_SEQ_EN
    logic [3:0] tens_q, tens_d, units_q, units_d;

    // BCD sequence number register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    // Advance 00..99 and wrap when the final byte of a message is taken.
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (handshake && last_byte) begin
            if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end
`endif

    // Output byte mux; zero whenever no byte is offered.
    always_comb begin
        out_data = 8'h00;
        if (state_q == SEND) begin
            out_data = base_byte(idx_q - BASE_OFS, val_q, BAD_CHAR);
`ifdef ROLL_SEQ_EN
            case (idx_q)
                4'd0:    out_data = ASC_HASH;
                4'd1:    out_data = ASC_ZERO + {4'd0, tens_q};
                4'd2:    out_data = ASC_ZERO + {4'd0, units_q};
                4'd3:    out_data = ASC_SPACE;
                default: ;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_roll_msg_formatter.sv
// Bench for roll_msg_formatter: reset state, latency, message content table,
// overflow, mid-message reset, randomized bursts with random backpressure,
// and (with ROLL_SEQ_EN) sequence-number wrap.
`timescale 1ns/1ps
module tb_roll_msg_formatter;

    localparam int         DEPTH = 4;
    localparam logic [7:0] BAD   = 8'h3F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] res_val = 3'd0;
    logic       res_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, busy, overflow;
    logic [2:0] fifo_level;

    always #5 clk = ~clk;

    roll_msg_formatter #(.FIFO_DEPTH(DEPTH), .BAD_CHAR(BAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_val    (res_val),
        .res_valid  (res_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    int n_vec = 0;
    int n_err = 0;
    int seq_no = 0;
    int rdy_mode = 0;   // 0: ready low, 1: ready high, 2: random
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic [2:0] v;
        logic [7:0] d;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference message: optional "#SS " prefix, "Rolled: ", digit, LF.
    function automatic void add_msg(input int v);
        string base = "Rolled: ";
`ifdef ROLL_SEQ_EN
        exp_q.push_back(8'h23);
        exp_q.push_back(8'(8'h30 + seq_no / 10));
        exp_q.push_back(8'(8'h30 + seq_no % 10));
        exp_q.push_back(8'h20);
        seq_no = (seq_no + 1) % 100;
`endif
        for (int i = 0; i < base.len(); i++) exp_q.push_back(base[i]);
        exp_q.push_back((v >= 1 && v <= 6) ? 8'(8'h30 + v) : BAD);
        exp_q.push_back(8'h0A);
    endfunction

    // out_ready driver, applied 2ns after each rising edge.
    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Byte collector and stall-stability monitor, sampled on the falling edge.
    initial begin
        logic       stall;
        logic [7:0] hold;
        stall = 1'b0;
        hold  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(hold));
                end
                if (out_valid && out_ready) got_q.push_back(out_data);
                stall = out_valid && !out_ready;
                hold  = out_data;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic [2:0] v);
        res_val   = v;
        res_valid = 1'b1;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while ((got_q.size() < exp_q.size() || busy) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: got %0d bytes, required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic compare_streams(input string name);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check(name, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        seq_no = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl = '{'{3'd0, 8'h3F}, '{3'd1, 8'h31}, '{3'd2, 8'h32}, '{3'd3, 8'h33},
                '{3'd4, 8'h34}, '{3'd5, 8'h35}, '{3'd6, 8'h36}, '{3'd7, 8'h3F}};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single result 3 with ready held: latency and consecutive bytes
        rdy_mode = 1;
        @(posedge clk);
        #1;
        add_msg(3);
        pulse(3'd3);
        check("lat_edgeN", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            check("seq_valid", 32'(out_valid), 32'd1);
            check("seq_byte", 32'(out_data), 32'(exp_q[i]));
            @(posedge clk);
            #1;
        end
        check("after_last_valid", 32'(out_valid), 32'd0);
        wait_done(50);
        compare_streams("single3");

        // Digit table under random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) begin
            add_msg(int'(tbl[i].v));
            pulse(tbl[i].v);
            wait_done(400);
            check("digit", (got_q.size() >= 2) ? 32'(got_q[got_q.size() - 2]) : 32'hFFFF_FFFF,
                  32'(tbl[i].d));
            compare_streams("table");
        end

        // Overflow: 1 goes in flight, 2..5 fill the FIFO, 6 is dropped
        rdy_mode = 0;
        @(posedge clk);
        #1;
        res_valid = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            res_val = 3'(v);
            @(posedge clk);
            #1;
        end
        res_valid = 1'b0;
        check("ovf_level_after5", 32'(fifo_level), 32'd4);
        pulse(3'd6);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_busy", 32'(busy), 32'd1);
        for (int v = 1; v <= 5; v++) add_msg(v);
        rdy_mode = 1;
        wait_done(300);
        compare_streams("overflow");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset after byte 4 of a message
        add_msg(5);
        begin
            int c = 0;
            pulse(3'd5);
            while (got_q.size() < 4 && c < 50) begin
                @(posedge clk);
                #1;
                c++;
            end
            check("mid_bytes", 32'(got_q.size()), 32'd4);
        end
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        seq_no = 0;
        got_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_resume_valid", 32'(out_valid), 32'd0);
        check("no_resume_bytes", 32'(got_q.size()), 32'd0);
        add_msg(2);
        pulse(3'd2);
        wait_done(50);
        compare_streams("fresh");

        // Randomized bursts (never more than DEPTH queued) with random ready
        rdy_mode = 2;
        for (int b = 0; b < 30; b++) begin
            int n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) begin
                int v = $urandom_range(0, 7);
                add_msg(v);
                pulse(3'(v));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            wait_done(1500);
        end
        compare_streams("random");
        check("random_overflow", 32'(overflow), 32'd0);

`ifdef ROLL_SEQ_EN
        // Sequence number 00..99 then wrap to 00
        do_reset();
        rdy_mode = 1;
        for (int m = 0; m < 101; m++) begin
            int v = $urandom_range(1, 6);
            add_msg(v);
            pulse(3'(v));
            wait_done(100);
        end
        compare_streams("seqwrap");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
